// File: rtl/param_loader.sv
// param_loader: loads N_PARAMS GPIO words into a shadow bank and commits them atomically.
// Optional build macro PARAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum word per load.
module param_loader #(
  parameter int unsigned GPIO_WIDTH  = 32,
  parameter int unsigned N_PARAMS    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LED_WIDTH   = 8
) (
  input  logic                           ADC_CLK,
  input  logic                           RST,
  input  logic [GPIO_WIDTH-1:0]          GPIO_0,
  input  logic [GPIO_WIDTH-1:0]          GPIO_1,
  output logic [N_PARAMS*GPIO_WIDTH-1:0] params,
  output logic                           params_valid,
  output logic                           commit_pulse,
  output logic                           load_error,
  output logic [LED_WIDTH-1:0]           LED_OUT
);

  // One bit wider than the LED field so N_PARAMS = 64 (plus checksum) cannot wrap.
  localparam int unsigned CntW = 7;
  localparam int unsigned IdxW = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StDone  = 2'd2,
    StError = 2'd3
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] en_sync_q, stb_sync_q;
  logic                   en_prev_q, stb_prev_q;
  logic [GPIO_WIDTH-1:0]  data_q;
  logic [GPIO_WIDTH-1:0]  shadow_q [N_PARAMS];
  logic [CntW-1:0]        count_q;
  logic                   commit_pend_q;
`ifdef PARAM_LOADER_CHECKSUM_EN
  logic [GPIO_WIDTH-1:0]  xor_q;
`endif

  logic en_s, stb_s, en_rise, en_fall, stb_rise;
  logic unused_gpio0;

  assign en_s     = en_sync_q[SYNC_STAGES-1];
  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign en_rise  = en_s & ~en_prev_q;
  assign en_fall  = ~en_s & en_prev_q;
  assign stb_rise = stb_s & ~stb_prev_q;

  assign unused_gpio0 = ^GPIO_0[GPIO_WIDTH-3:0];

  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      en_sync_q     <= '0;
      stb_sync_q    <= '0;
      en_prev_q     <= 1'b0;
      stb_prev_q    <= 1'b0;
      data_q        <= '0;
      count_q       <= '0;
      commit_pend_q <= 1'b0;
      params        <= '0;
      params_valid  <= 1'b0;
      commit_pulse  <= 1'b0;
      load_error    <= 1'b0;
      for (int k = 0; k < N_PARAMS; k++) shadow_q[k] <= '0;
`ifdef PARAM_LOADER_CHECKSUM_EN
      xor_q         <= '0;
`endif
    end else begin
      en_sync_q     <= {en_sync_q[SYNC_STAGES-2:0], GPIO_0[GPIO_WIDTH-1]};
      stb_sync_q    <= {stb_sync_q[SYNC_STAGES-2:0], GPIO_0[GPIO_WIDTH-2]};
      en_prev_q     <= en_s;
      stb_prev_q    <= stb_s;
      data_q        <= GPIO_1;
      commit_pulse  <= 1'b0;
      commit_pend_q <= 1'b0;

      // A complete set is always published; a coincident EN edge only redirects the state.
      if (commit_pend_q) begin
        for (int k = 0; k < N_PARAMS; k++) params[k*GPIO_WIDTH +: GPIO_WIDTH] <= shadow_q[k];
        params_valid <= 1'b1;
        commit_pulse <= 1'b1;
        state_q      <= StDone;
      end

      if (en_rise) begin
        state_q    <= StLoad;
        count_q    <= '0;
        load_error <= 1'b0;
`ifdef PARAM_LOADER_CHECKSUM_EN
        xor_q      <= '0;
`endif
      end else if (en_fall) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StLoad: begin
            if (stb_rise) begin
              if (count_q < CntW'(N_PARAMS)) begin
                shadow_q[count_q[IdxW-1:0]] <= data_q;
                count_q                     <= count_q + CntW'(1);
`ifdef PARAM_LOADER_CHECKSUM_EN
                xor_q                       <= xor_q ^ data_q;
`else
                if (count_q == CntW'(N_PARAMS - 1)) commit_pend_q <= 1'b1;
`endif
              end
`ifdef PARAM_LOADER_CHECKSUM_EN
              else if (count_q == CntW'(N_PARAMS)) begin
                count_q <= count_q + CntW'(1);
                if (data_q == xor_q) begin
                  commit_pend_q <= 1'b1;
                end else begin
                  state_q    <= StError;
                  load_error <= 1'b1;
                end
              end
`endif
            end
          end
          StDone: begin
            if (stb_rise) begin
              state_q    <= StError;
              load_error <= 1'b1;
            end
          end
          StIdle, StError: ;
        endcase
      end
    end
  end

  logic [7:0] led_raw;
  assign led_raw = {state_q, count_q[5:0]};

  if (LED_WIDTH > 8) begin : g_led_wide
    assign LED_OUT = {{(LED_WIDTH-8){1'b0}}, led_raw};
  end else begin : g_led_narrow
    assign LED_OUT = led_raw[LED_WIDTH-1:0];
  end

endmodule
